// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a 2-entry skid buffer,
// synchronous flush, occupancy output and saturating stall/flush-drop counters.
module pipe_stage_skid #(
    parameter int unsigned DATA_W         = 140,
    parameter bit          CLEAR_ON_FLUSH = 1'b1,
    parameter int unsigned CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_drop_cnt
);

    localparam int unsigned SUM_W = CNT_W + 1;

    // Encoding keeps skid-valid-without-main-valid unrepresentable.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_main_d;
    logic [DATA_W-1:0]   r_skid_d;
    logic                r_in_ready;
    logic                r_rst_done;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    logic                w_main_v;
    logic                w_skid_v;
    logic                w_acc;
    logic                w_dep;
    logic                w_ld_main_in;
    logic                w_ld_main_skid;
    logic                w_ld_skid;
    logic                w_stall_inc;
    logic [SUM_W-1:0]    w_flush_sum;

    assign w_main_v       = (r_state != ST_EMPTY);
    assign w_skid_v       = (r_state == ST_FULL);
    assign w_acc          = in_valid & r_in_ready;
    assign w_dep          = w_main_v & out_ready;
    assign w_stall_inc    = w_main_v & ~out_ready & ~flush;
    assign w_flush_sum    = {1'b0, r_flush_cnt} + SUM_W'(occupancy);

    assign in_ready       = r_in_ready;
    assign out_valid      = w_main_v;
    assign out_data       = r_main_d;
    assign occupancy      = {1'b0, w_main_v} + {1'b0, w_skid_v};
    assign stall_cnt      = r_stall_cnt;
    assign flush_drop_cnt = r_flush_cnt;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and data-load strobes; flush overrides any transfer.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_acc) begin
                        w_state_nxt  = ST_ONE;
                        w_ld_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_acc && w_dep) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_acc) begin
                        w_state_nxt = ST_FULL;
                        w_ld_skid   = 1'b1;
                    end else if (w_dep) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_dep) begin
                        w_state_nxt    = ST_ONE;
                        w_ld_main_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Payload registers; flush optionally scrubs them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main_d <= '0;
            r_skid_d <= '0;
        end else if (flush) begin
            if (CLEAR_ON_FLUSH) begin
                r_main_d <= '0;
                r_skid_d <= '0;
            end
        end else begin
            if (w_ld_main_in) begin
                r_main_d <= in_data;
            end else if (w_ld_main_skid) begin
                r_main_d <= r_skid_d;
            end
            if (w_ld_skid) begin
                r_skid_d <= in_data;
            end
        end
    end

    // Registered ready; held low for one extra cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_done <= 1'b0;
            r_in_ready <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
            r_in_ready <= (w_state_nxt != ST_FULL) & r_rst_done;
        end
    end

    // Saturating performance counters, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (flush) begin
                r_flush_cnt <= w_flush_sum[CNT_W] ? {CNT_W{1'b1}} : w_flush_sum[CNT_W-1:0];
            end
        end
    end

    // Held output payload must not change under back-pressure.
    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> $stable(out_data));

    // Full occupancy must never coincide with ready.
    a_no_ready_full: assert property (@(posedge clk) disable iff (reset)
        !((occupancy == 2'd2) && in_ready));

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: default instance, a no-clear-on-flush
// instance and a 4-bit-counter instance share one stimulus stream.
module tb_pipe_stage_skid;

    localparam int unsigned DW = 140;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt, flush_drop_cnt;

    logic          nc_in_ready, nc_out_valid;
    logic [DW-1:0] nc_out_data;
    logic [1:0]    nc_occupancy;
    logic [15:0]   nc_stall_cnt, nc_flush_drop_cnt;

    logic          sat_in_ready, sat_out_valid;
    logic [DW-1:0] sat_out_data;
    logic [1:0]    sat_occupancy;
    logic [3:0]    sat_stall_cnt, sat_flush_drop_cnt;

    int n_cmp;
    int n_err;

    pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_drop_cnt(flush_drop_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b0), .CNT_W(16)) u_nc (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
        .occupancy(nc_occupancy), .stall_cnt(nc_stall_cnt), .flush_drop_cnt(nc_flush_drop_cnt)
    );

    pipe_stage_skid #(.DATA_W(DW), .CLEAR_ON_FLUSH(1'b1), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt), .flush_drop_cnt(sat_flush_drop_cnt)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state.
        step(3);
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_occ", DW'(occupancy), DW'(0));
        check("rst_stall", DW'(stall_cnt), DW'(0));
        check("rst_fdrop", DW'(flush_drop_cnt), DW'(0));
        reset = 1'b0;

        // Ready rises on the second edge after release.
        step(1);
        check("rel_edge1_ready", DW'(in_ready), DW'(0));
        step(1);
        check("rel_edge2_ready", DW'(in_ready), DW'(1));

        // Streaming with out_ready held high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_data = DW'(i);
            step(1);
            check($sformatf("stream_data%0d", i), out_data, DW'(i));
            check($sformatf("stream_occ%0d", i), DW'(occupancy), DW'(1));
        end
        in_valid = 1'b0;
        step(1);
        check("stream_drain_valid", DW'(out_valid), DW'(0));
        check("stream_stall", DW'(stall_cnt), DW'(0));

        // Back-pressure: fill with A, B.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'hA);
        step(1);
        in_data   = DW'(32'hB);
        step(1);
        in_valid  = 1'b0;
        check("bp_occ", DW'(occupancy), DW'(2));
        check("bp_in_ready", DW'(in_ready), DW'(0));
        check("bp_data", out_data, DW'(32'hA));
        step(2);
        check("bp_stall3", DW'(stall_cnt), DW'(3));
        check("bp_data_held", out_data, DW'(32'hA));
        out_ready = 1'b1;
        step(1);
        check("bp_second", out_data, DW'(32'hB));
        check("bp_ready_back", DW'(in_ready), DW'(1));
        check("bp_occ1", DW'(occupancy), DW'(1));
        step(1);
        check("bp_empty", DW'(occupancy), DW'(0));

        // Flush while FULL with a competing input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'hA);
        step(1);
        in_data   = DW'(32'hB);
        step(1);
        check("fl_full", DW'(occupancy), DW'(2));
        flush     = 1'b1;
        in_data   = DW'(32'hC);
        step(1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        check("fl_occ", DW'(occupancy), DW'(0));
        check("fl_valid", DW'(out_valid), DW'(0));
        check("fl_drop", DW'(flush_drop_cnt), DW'(2));
        check("fl_cleared", out_data, DW'(0));
        check("fl_nc_kept", nc_out_data, DW'(32'hA));
        check("fl_ready", DW'(in_ready), DW'(1));
        check("fl_stall", DW'(stall_cnt), DW'(4));
        out_ready = 1'b1;
        step(1);
        check("fl_no_c", DW'(out_valid), DW'(0));

        // Flush while EMPTY leaves the drop counter alone.
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        check("fl_empty_drop", DW'(flush_drop_cnt), DW'(2));

        // Flush one held entry; no-clear instance keeps its payload.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(32'h5);
        step(1);
        in_valid  = 1'b0;
        flush     = 1'b1;
        step(1);
        flush     = 1'b0;
        check("nc_valid", DW'(nc_out_valid), DW'(0));
        check("nc_data", nc_out_data, DW'(32'h5));
        check("nc_drop", DW'(nc_flush_drop_cnt), DW'(3));
        check("clr_data", out_data, DW'(0));

        // Counter saturation over 20 stalled cycles.
        in_valid = 1'b1;
        in_data  = DW'(32'h7);
        step(1);
        in_valid = 1'b0;
        step(20);
        check("sat_stall", DW'(sat_stall_cnt), DW'(15));
        check("wide_stall", DW'(stall_cnt), DW'(24));

        // Async reset mid-cycle while FULL.
        in_valid = 1'b1;
        in_data  = DW'(32'h8);
        step(1);
        in_valid = 1'b0;
        check("ar_full", DW'(occupancy), DW'(2));
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid", DW'(out_valid), DW'(0));
        check("ar_data", out_data, DW'(0));
        check("ar_occ", DW'(occupancy), DW'(0));
        check("ar_ready", DW'(in_ready), DW'(0));
        check("ar_drop", DW'(flush_drop_cnt), DW'(0));
        check("ar_stall", DW'(stall_cnt), DW'(0));
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-field inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries one opaque payload bus of DATA_W bits between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so back-pressure never combinationally couples the stages.
- Adds synchronous flush, an occupancy indicator and saturating stall/flush performance counters. The fixed registers support none of these.

Parameters:
- DATA_W, 140, payload width in bits (packed stage fields).
- CLEAR_ON_FLUSH, 1, 1: flush zeroes both data registers; 0: data registers hold their contents and only valids clear.
- CNT_W, 16, width of the stall and flush-drop counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream payload valid
- in_ready  out  1  registered; upstream may transfer when high
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream payload valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  payload to downstream (main register)
- occupancy  out  2  entries held: 0, 1 or 2
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_drop_cnt  out  CNT_W  valid entries discarded by flush, saturating

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d). out_valid=main_v, out_data=main_d.
- State encoding is implied by the valids:
  - EMPTY: main_v=0, skid_v=0
  - ONE: main_v=1, skid_v=0
  - FULL: both valid
  - main_v=0 with skid_v=1 is illegal and must never occur.
- Transfer definitions: acc = in_valid & in_ready; dep = out_valid & out_ready.
- in_ready is a flop. Next value = (next state != FULL) & !reset_release_cycle. It is never driven combinationally from out_ready.
- Transitions when flush=0:
  - EMPTY: acc → ONE, main_d<=in_data.
  - ONE, acc & dep → ONE, main_d<=in_data.
  - ONE, acc & !dep → FULL, skid_d<=in_data.
  - ONE, !acc & dep → EMPTY.
  - ONE, neither → hold.
  - FULL: in_ready=0, so acc=0. dep → ONE, main_d<=skid_d. Otherwise hold.
- Ordering: strict FIFO order. No payload is duplicated or dropped except by flush.
- Latency: in_data appears on out_data 1 cycle after acceptance when the block was EMPTY (or ONE with a same-cycle departure). Minimum latency is 1 cycle. Throughput is 1 per cycle when out_ready is held high.
- Flush (highest priority after reset):
  - Next state is EMPTY. in_ready=1 next cycle.
  - Any same-cycle acc or dep is ignored: the input is dropped and the output is not counted as transferred.
  - If CLEAR_ON_FLUSH=1, main_d and skid_d are set to 0.
  - flush_drop_cnt += occupancy (0/1/2), saturating at 2^CNT_W−1.
  - A flush while EMPTY changes nothing except in_ready.
- stall_cnt: +1 on each clock where out_valid=1 and out_ready=0 and flush=0. It saturates at all-ones and does not wrap.
- Counters clear only on reset.
- Reset (async assert, synchronous release):
  - While reset is asserted: all valids=0, data=0, occupancy=0, in_ready=0, stall_cnt=0, flush_drop_cnt=0.
  - in_ready rises on the second rising edge after deassertion.
  - Reset asserted mid-transfer discards all entries immediately and does not count them as flush drops.
- occupancy = main_v + skid_v, registered-equivalent; it must never read 2 while in_ready=1.
- Assertions:
  - Never skid_v & !main_v.
  - out_data stable while out_valid & !out_ready.

Test Plan:
- Reset then stream: out_ready=1, in_valid=1 with in_data=1,2,3,4 on successive cycles → out_data=1,2,3,4 one cycle later each, occupancy=1, stall_cnt=0.
- Back-pressure: load 0xA, 0xB with out_ready=0 → occupancy=2, in_ready=0, out_data=0xA held. After 3 stalled cycles stall_cnt=3. Raise out_ready → 0xA then 0xB, in_ready returns to 1.
- Flush when FULL (0xA, 0xB held) with in_valid=1, in_data=0xC → next cycle occupancy=0, out_valid=0, flush_drop_cnt=2, out_data=0 (CLEAR_ON_FLUSH=1), 0xC never appears.
- Flush with CLEAR_ON_FLUSH=0 and 0x5 held → out_valid=0, out_data stays 0x5, flush_drop_cnt=1.
- Saturation: CNT_W=4, hold out_valid=1/out_ready=0 for 20 cycles → stall_cnt=15, no wrap.
- Async reset asserted mid-cycle while FULL → outputs zero before the next clock edge, in_ready=0, flush_drop_cnt unchanged at 0.
